// File: rtl/if_pkg.sv
// if_pkg: shared constants and types for the instruction-fetch queue.
//   ADDR_W / DATA_W : default address and instruction widths
//   RstEnable       : asserted level of rst
//   ChipEnable      : value driven on ce once out of reset
//   q_entry_t       : queue entry {pc, instr} at the default widths
package if_pkg;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam logic RstEnable = 1'b1;
  localparam logic ChipEnable = 1'b1;
  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] instr;
  } q_entry_t;
endpackage

// File: rtl/if_fifo.sv
// if_fifo: synchronous FIFO with a one-cycle clear.
//   clk, rst          : clock, asynchronous active-high reset
//   clr_i             : drop all entries (wins over push/pop)
//   push_i, din_i     : write an entry
//   pop_i             : remove the head entry
//   dout_o            : head entry (valid when empty_o is low)
//   empty_o, count_o  : occupancy status
module if_fifo import if_pkg::*; #(
  parameter int W = 32,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic [W-1:0] dout_o,
  output logic         empty_o,
  output logic [AW:0]  count_o
);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0] wr_q, wr_d, rd_q, rd_d;
  always_comb begin
    wr_d = clr_i ? '0 : wr_q + (AW+1)'(push_i);
    rd_d = clr_i ? '0 : rd_q + (AW+1)'(pop_i);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end
  always_ff @(posedge clk)
    if (push_i & ~clr_i) mem_q[wr_q[AW-1:0]] <= din_i;
  assign dout_o = mem_q[rd_q[AW-1:0]];
  assign empty_o = wr_q == rd_q;
  assign count_o = wr_q - rd_q;
endmodule

// File: rtl/if_fetch_queue.sv
// if_fetch_queue: pipelined instruction fetch with a small output queue.
//   clk, rst                      : clock, asynchronous active-high reset
//   is_hold                       : stop issuing new fetches
//   is_branch, branch_address     : one-cycle redirect and its target
//   ce                            : memory chip enable (registered)
//   imem_req/addr/gnt             : request handshake to instruction memory
//   imem_rvalid/rdata             : in-order responses, latency >= 1
//   out_valid/ready/instr/pc/pc_plus4 : queue head towards IF_ID
//   out_misalign                  : sticky misaligned-redirect flag
// Optional feature macro IF_ALIGN_CHECK_EN: misaligned redirects halt
// fetching and raise out_misalign; otherwise targets are forced word-aligned.
module if_fetch_queue import if_pkg::*; #(
  parameter int ADDR_W = if_pkg::ADDR_W,
  parameter int DATA_W = if_pkg::DATA_W,
  parameter int DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              is_hold,
  input  logic              is_branch,
  input  logic [ADDR_W-1:0] branch_address,
  output logic              ce,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_instr,
  output logic [ADDR_W-1:0] out_pc,
  output logic [ADDR_W-1:0] out_pc_plus4,
  output logic              out_misalign
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int AW = $clog2(DEPTH);
  logic [ADDR_W-1:0] pc_q, pc_d, target, tag_pc;
  logic [CW-1:0] inflight_q, inflight_d, drop_q, drop_d;
  logic ce_q, halt, credit, accept, resp_keep, deq, q_empty;
  logic [AW:0] q_count, tag_count_unused;
  logic tag_empty_unused;
`ifdef IF_ALIGN_CHECK_EN
  logic misalign_q, misalign_d;
  assign target = branch_address;
  assign misalign_d = is_branch ? |branch_address[1:0] : misalign_q;
  always_ff @(posedge clk or posedge rst)
    if (rst == RstEnable) misalign_q <= 1'b0;
    else misalign_q <= misalign_d;
  assign halt = misalign_q;
  assign out_misalign = misalign_q;
`else
  logic unused_low;
  assign unused_low = ^branch_address[1:0];
  assign target = {branch_address[ADDR_W-1:2], 2'b00};
  assign halt = 1'b0;
  assign out_misalign = 1'b0;
`endif
  // Outstanding requests (including ones to be dropped) reserve queue slots,
  // so a response can always be pushed without checking for full.
  assign credit = (32'(q_count) + 32'(inflight_q)) < 32'(DEPTH);
  assign imem_req = ce_q & ~is_hold & ~is_branch & ~halt & credit;
  assign imem_addr = pc_q;
  assign ce = ce_q;
  assign accept = imem_req & imem_gnt;
  assign resp_keep = imem_rvalid & (drop_q == '0) & ~is_branch;
  assign deq = out_valid & out_ready & ~is_branch;
  assign out_valid = ~q_empty;
  assign out_pc_plus4 = out_pc + ADDR_W'(4);
  always_comb begin
    pc_d = is_branch ? target : accept ? pc_q + ADDR_W'(4) : pc_q;
    inflight_d = inflight_q + CW'(accept) - CW'(imem_rvalid);
    // A response in the redirect cycle is already discarded, so it is not
    // counted among the ones still to be dropped.
    drop_d = is_branch ? inflight_q - CW'(imem_rvalid)
                       : drop_q - CW'(imem_rvalid & (drop_q != '0));
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      pc_q <= RESET_PC;
      ce_q <= 1'b0;
      inflight_q <= '0;
      drop_q <= '0;
    end else begin
      pc_q <= pc_d;
      ce_q <= ChipEnable;
      inflight_q <= inflight_d;
      drop_q <= drop_d;
    end
  end
  // Tags of dropped requests are discarded by the clear, so only kept
  // responses pop a tag.
  if_fifo #(.W(ADDR_W), .DEPTH(DEPTH)) u_tag (
    .clk(clk), .rst(rst), .clr_i(is_branch), .push_i(accept), .din_i(pc_q),
    .pop_i(resp_keep), .dout_o(tag_pc), .empty_o(tag_empty_unused),
    .count_o(tag_count_unused)
  );
  if_fifo #(.W(ADDR_W+DATA_W), .DEPTH(DEPTH)) u_queue (
    .clk(clk), .rst(rst), .clr_i(is_branch), .push_i(resp_keep),
    .din_i({tag_pc, imem_rdata}), .pop_i(deq), .dout_o({out_pc, out_instr}),
    .empty_o(q_empty), .count_o(q_count)
  );
endmodule
